// File: rtl/a_cross_arbiter_if.sv
// a_cross_arbiter_if: source request/data bus and RS232 byte handshake of the cross arbiter
interface a_cross_arbiter_if;
  logic [3:0]  req_i;
  logic [63:0] data_i;
  logic [3:0]  dv_i;
  logic [3:0]  word_ack_o;
  logic [3:0]  grant_o;
  logic [7:0]  uart_data_o;
  logic        uart_wr_o;
  logic        uart_busy_i;
  modport slave (input req_i, data_i, dv_i, uart_busy_i, output word_ack_o, grant_o, uart_data_o, uart_wr_o);
  modport master (output req_i, data_i, dv_i, uart_busy_i, input word_ack_o, grant_o, uart_data_o, uart_wr_o);
endinterface

// File: rtl/a_cross_arbiter.sv
// a_cross_arbiter: round-robin 4-source arbiter serialising 16-bit word bursts into RS232 bytes
// CROSS_ARB_HEADER_EN: emit a {4'hA, 2'b00, idx} header byte at the start of every grant
module a_cross_arbiter #(
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 255
) (
  input logic             clk_i,
  input logic             rst_i,
  a_cross_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ARB, GNT, SEND_HI, GAP_HI, SEND_LO, GAP_LO, REL} state_t;
  state_t      r_state;
  logic [3:0]  r_grant, r_ack;
  logic [1:0]  r_idx, r_ptr;
  logic [15:0] r_word;
  logic [7:0]  r_burst, r_tmo, r_data;
  logic        r_wr, r_hdr;
  logic [1:0]  w_pick;
  logic        w_req, w_dv, w_rel;
  logic [15:0] w_data;
  always_comb begin
    w_pick = r_ptr;
    for (int k = 4; k >= 1; k--)
      if (bus.req_i[r_ptr + 2'(k)]) w_pick = r_ptr + 2'(k);
  end
  assign w_req  = bus.req_i[r_idx];
  assign w_dv   = bus.dv_i[r_idx];
  assign w_data = bus.data_i[{r_idx, 4'b0000} +: 16];
  assign w_rel  = !w_req || r_burst == 8'(MAX_BURST) || r_tmo == 8'(IDLE_TIMEOUT);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ack   <= '0;
      r_idx   <= '0;
      r_ptr   <= 2'd3;
      r_word  <= '0;
      r_burst <= '0;
      r_tmo   <= '0;
      r_data  <= '0;
      r_wr    <= 1'b0;
      r_hdr   <= 1'b0;
    end else begin
      r_ack <= '0;
      r_wr  <= 1'b0;
      case (r_state)
        IDLE: if (|bus.req_i) r_state <= ARB;
        ARB: begin
          if (|bus.req_i) begin
            r_grant <= 4'b0001 << w_pick;
            r_idx   <= w_pick;
            r_burst <= '0;
            r_tmo   <= '0;
`ifdef CROSS_ARB_HEADER_EN
            r_hdr   <= 1'b1;
            r_state <= SEND_HI;
`else
            r_state <= GNT;
`endif
          end else r_state <= IDLE;
        end
        GNT: begin
          if (w_rel) begin
            r_grant <= '0;
            r_state <= REL;
          end else if (w_dv) begin
            r_word  <= w_data;
            r_ack   <= r_grant;
            r_tmo   <= '0;
            r_state <= SEND_HI;
          end else r_tmo <= r_tmo + 8'd1;
        end
        SEND_HI: if (!bus.uart_busy_i) begin
          r_data  <= r_hdr ? {4'hA, 2'b00, r_idx} : r_word[15:8];
          r_wr    <= 1'b1;
          r_state <= GAP_HI;
        end
        // transmitter raises busy a cycle after the strobe, so the gap never samples it
        GAP_HI: begin
          r_hdr   <= 1'b0;
          r_state <= r_hdr ? GNT : SEND_LO;
        end
        SEND_LO: if (!bus.uart_busy_i) begin
          r_data  <= r_word[7:0];
          r_wr    <= 1'b1;
          r_state <= GAP_LO;
        end
        GAP_LO: begin
          r_burst <= r_burst + 8'd1;
          r_state <= GNT;
        end
        REL: begin
          r_ptr   <= r_idx;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.grant_o     = r_grant;
  assign bus.word_ack_o  = r_ack;
  assign bus.uart_data_o = r_data;
  assign bus.uart_wr_o   = r_wr;
endmodule

// File: tb/tb_a_cross_arbiter.sv
// tb_a_cross_arbiter: vector table, corner sequences and random traffic against a transaction-level model
module tb_a_cross_arbiter;
  localparam int MB = 3;
  localparam int TO = 10;
`ifdef CROSS_ARB_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  a_cross_arbiter_if bus();
  a_cross_arbiter #(.MAX_BURST(MB), .IDLE_TIMEOUT(TO)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  typedef struct {int src; int n;} ep_t;
  typedef struct {int src; logic [15:0] w; logic [3:0] exp_grant; logic [7:0] exp_hi; logic [7:0] exp_lo;} vec_t;
  int n_cmp = 0, n_err = 0, cyc = 0, last_src = 3, ep_src = 0;
  logic [15:0] sq [4][$];
  logic [15:0] txq [4][$];
  logic [15:0] rxq [4][$];
  logic [7:0]  bytes_q[$], exp_q[$], ep_b[$];
  ep_t         ep_log[$];
  int          ack_cnt[4];
  logic [3:0]  force_req = '0, force_dv = '0, g_prev = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int rr(input int last, input logic [3:0] req);
    for (int k = 1; k <= 4; k++) if (req[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      bus.req_i[i] = sq[i].size() > 0 || force_req[i];
      bus.dv_i[i]  = sq[i].size() > 0 || force_dv[i];
      bus.data_i[16*i +: 16] = sq[i].size() > 0 ? sq[i][0] : 16'hDEAD;
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 4; i++) begin
      txq[i].delete();
      rxq[i].delete();
      ack_cnt[i] = 0;
    end
    bytes_q.delete();
    exp_q.delete();
    ep_log.delete();
  endtask

  task automatic ep_end();
    int b, n;
    b = 0;
    if (HDR) begin
      chk("hdr_present", ep_b.size() > 0, 1);
      chk("hdr_byte", ep_b.size() > 0 ? ep_b[0] : 8'h00, {4'hA, 2'b00, 2'(ep_src)});
      b = 1;
    end
    chk("ep_whole_words", (ep_b.size() - b) % 2, 0);
    n = (ep_b.size() - b) / 2;
    chk("ep_burst_le_max", n <= MB, 1);
    for (int k = 0; k < n; k++) rxq[ep_src].push_back({ep_b[b+2*k], ep_b[b+2*k+1]});
    ep_log.push_back('{ep_src, n});
    ep_b.delete();
  endtask

  task automatic step();
    logic bprev;
    logic [3:0] rq;
    @(posedge clk);
    #1;
    cyc++;
    bprev = bus.uart_busy_i;
    rq = bus.req_i;
    if (bus.word_ack_o != 4'b0000) begin
      chk("ack_is_grant", bus.word_ack_o, bus.grant_o);
      for (int i = 0; i < 4; i++)
        if (bus.word_ack_o[i]) begin
          ack_cnt[i]++;
          if (sq[i].size() > 0) txq[i].push_back(sq[i].pop_front());
        end
    end
    if (bus.uart_wr_o) begin
      chk("strobe_after_busy_low", bprev, 0);
      bytes_q.push_back(bus.uart_data_o);
      ep_b.push_back(bus.uart_data_o);
    end
    if (bus.grant_o != g_prev) begin
      chk("no_direct_handover", g_prev != 0 && bus.grant_o != 0, 0);
      if (bus.grant_o != 0) begin
        chk("grant_onehot", $onehot(bus.grant_o), 1);
        for (int i = 0; i < 4; i++) if (bus.grant_o[i]) ep_src = i;
        chk("rr_pick", ep_src, rr(last_src, rq));
        last_src = ep_src;
        ep_b.delete();
      end else ep_end();
      g_prev = bus.grant_o;
    end
    drive();
  endtask

  task automatic run_idle(input int budget);
    int quiet, n;
    quiet = 0;
    n = 0;
    while (quiet < 6 && n < budget) begin
      step();
      n++;
      quiet = (sq[0].size() + sq[1].size() + sq[2].size() + sq[3].size() == 0 && force_req == 0 &&
               bus.grant_o == 0 && !bus.uart_wr_o) ? quiet + 1 : 0;
    end
    chk("drain_in_budget", quiet >= 6, 1);
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    #1;
    chk({nm, "_grant"}, bus.grant_o, 0);
    chk({nm, "_ack"}, bus.word_ack_o, 0);
    chk({nm, "_wr"}, bus.uart_wr_o, 0);
    chk({nm, "_data"}, bus.uart_data_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
    g_prev = '0;
    last_src = 3;
    ep_b.delete();
  endtask

  task automatic exp_word(input int s, input logic [15:0] w, input bit hdr);
    if (hdr && HDR) exp_q.push_back({4'hA, 2'b00, 2'(s)});
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic cmp_bytes(input string nm);
    chk({nm, "_nbytes"}, bytes_q.size(), exp_q.size());
    for (int k = 0; k < bytes_q.size() && k < exp_q.size(); k++) chk({nm, "_byte"}, bytes_q[k], exp_q[k]);
  endtask

  task automatic check_flow(input string nm);
    for (int i = 0; i < 4; i++) begin
      chk({nm, "_nwords"}, rxq[i].size(), txq[i].size());
      for (int k = 0; k < rxq[i].size() && k < txq[i].size(); k++) chk({nm, "_word"}, rxq[i][k], txq[i][k]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int n, k, s, fall, gcnt;
    tbl = '{'{0, 16'h1234, 4'b0001, 8'h12, 8'h34}, '{1, 16'hABCD, 4'b0010, 8'hAB, 8'hCD},
            '{2, 16'h0001, 4'b0100, 8'h00, 8'h01}, '{3, 16'hFF00, 4'b1000, 8'hFF, 8'h00},
            '{3, 16'h8001, 4'b1000, 8'h80, 8'h01}, '{0, 16'h0000, 4'b0001, 8'h00, 8'h00}};
    bus.uart_busy_i = 1'b0;
    drive();
    #2;
    do_reset("reset");
    for (int i = 0; i < 6; i++) begin
      clear_logs();
      sq[tbl[i].src].push_back(tbl[i].w);
      drive();
      run_idle(100);
      chk("vec_episodes", ep_log.size(), 1);
      if (ep_log.size() > 0) chk("vec_grant", 4'b0001 << ep_log[0].src, tbl[i].exp_grant);
      if (HDR) exp_q.push_back({4'hA, 2'b00, 2'(tbl[i].src)});
      exp_q.push_back(tbl[i].exp_hi);
      exp_q.push_back(tbl[i].exp_lo);
      cmp_bytes("vec");
      chk("vec_acks", ack_cnt[tbl[i].src], 1);
    end
    // single source, three words in one burst
    clear_logs();
    sq[1].push_back(16'h1234);
    sq[1].push_back(16'hABCD);
    sq[1].push_back(16'h0001);
    drive();
    run_idle(200);
    exp_word(1, 16'h1234, 1);
    exp_word(1, 16'hABCD, 0);
    exp_word(1, 16'h0001, 0);
    cmp_bytes("t1");
    chk("t1_acks", ack_cnt[1], 3);
    chk("t1_episodes", ep_log.size(), 1);
    if (ep_log.size() > 0) chk("t1_burst", ep_log[0].n, 3);
    // all four sources competing, bursts capped at MB
    do_reset("t2_reset");
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < MB + 1; j++) sq[i].push_back(16'(i * 16'h1111 + j));
    drive();
    run_idle(800);
    chk("t2_episodes", ep_log.size(), 8);
    for (int e = 0; e < ep_log.size() && e < 8; e++) begin
      chk("t2_order", ep_log[e].src, e % 4);
      chk("t2_burst", ep_log[e].n, e < 4 ? MB : 1);
    end
    check_flow("t2");
    // transmitter busy for 20 cycles after the first strobe
    clear_logs();
    sq[0].push_back(16'h5AA5);
    sq[0].push_back(16'h3CC3);
    drive();
    n = 0;
    while (!bus.uart_wr_o && n < 50) begin step(); n++; end
    chk("t3_first_strobe", bus.uart_wr_o, 1);
    bus.uart_busy_i = 1'b1;
    s = 0;
    repeat (20) begin step(); s += int'(bus.uart_wr_o); end
    chk("t3_no_strobe_while_busy", s, 0);
    bus.uart_busy_i = 1'b0;
    fall = cyc;
    n = 0;
    while (!bus.uart_wr_o && n < 50) begin step(); n++; end
    chk("t3_resume_cycle", cyc, fall + 1);
    run_idle(200);
    exp_word(0, 16'h5AA5, 1);
    exp_word(0, 16'h3CC3, 0);
    cmp_bytes("t3");
    check_flow("t3");
    // granted source never presents dv: timeout, then hand over to source 3
    clear_logs();
    force_req[2] = 1'b1;
    drive();
    n = 0;
    while (bus.grant_o != 4'b0100 && n < 20) begin step(); n++; end
    chk("t4_grant2", bus.grant_o, 4'b0100);
    gcnt = 1;
    sq[3].push_back(16'h7E81);
    force_dv[0] = 1'b1;
    drive();
    n = 0;
    while (bus.grant_o != 4'b1000 && n < 100) begin
      step();
      n++;
      if (bus.grant_o == 4'b0100) gcnt++;
    end
    chk("t4_grant3", bus.grant_o, 4'b1000);
    chk("t4_grant2_cycles", gcnt, TO + 1 + (HDR ? 2 : 0));
    force_req[2] = 1'b0;
    force_dv[0] = 1'b0;
    drive();
    run_idle(200);
    if (HDR) exp_q.push_back(8'hA2);
    exp_word(3, 16'h7E81, 1);
    cmp_bytes("t4");
    chk("t4_no_ack_src0", ack_cnt[0], 0);
    chk("t4_episodes", ep_log.size(), 2);
    if (ep_log.size() == 2) begin
      chk("t4_ep0_words", ep_log[0].n, 0);
      chk("t4_ep1_src", ep_log[1].src, 3);
    end
    // reset while the low byte waits on busy
    do_reset("t5_pre");
    sq[1].push_back(16'h9669);
    sq[1].push_back(16'h0F0F);
    drive();
    k = 0;
    n = 0;
    while (k < (HDR ? 2 : 1) && n < 50) begin
      step();
      n++;
      if (bus.uart_wr_o) k++;
    end
    chk("t5_hi_sent", bus.uart_data_o, 8'h96);
    bus.uart_busy_i = 1'b1;
    sq[0].push_back(16'hC3C3);
    drive();
    step();
    step();
    do_reset("t5_rst");
    bus.uart_busy_i = 1'b0;
    run_idle(200);
    exp_word(0, 16'hC3C3, 1);
    exp_word(1, 16'h0F0F, 1);
    cmp_bytes("t5");
    if (ep_log.size() > 0) chk("t5_first_src", ep_log[0].src, 0);
    // random traffic and busy
    clear_logs();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        s = $urandom_range(0, 3);
        if (sq[s].size() < 6) sq[s].push_back(16'($urandom));
      end
      bus.uart_busy_i = 1'($urandom_range(0, 1));
      drive();
      step();
    end
    bus.uart_busy_i = 1'b0;
    run_idle(2000);
    check_flow("rand");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
